// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with clock and stopwatch views,
// colon blink and alarm flash. A whole frame (digits 0..3) is drawn from one
// snapshot of the inputs taken when the scan wraps from digit 3 to digit 0.
module seven_seg_display_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       view_sel,
    input  logic [1:0] tens_hours_in,
    input  logic [3:0] units_hours_in,
    input  logic [2:0] tens_minutes_in,
    input  logic [3:0] units_minutes_in,
    input  logic [5:0] stopwatch_min_in,
    input  logic [5:0] stopwatch_sec_in,
    input  logic       alarm_sound,
    output logic [6:0] seg_out,
    output logic [3:0] an_out,
    output logic       dp_out,
    output logic       buzzer_out
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    // Internal digit codes beyond 0-9
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blk_cnt;
    logic [1:0]    idx;
    logic          blink_phase;

    logic          sh_view;
    logic [1:0]    sh_th;
    logic [3:0]    sh_uh;
    logic [2:0]    sh_tm;
    logic [3:0]    sh_um;
    logic [5:0]    sh_smin;
    logic [5:0]    sh_ssec;
    logic          sh_alarm;

    logic          ref_tc, blk_tc, frame_start, phase_nxt;
    logic [1:0]    idx_nxt;
    logic          n_view, n_alarm;
    logic [1:0]    n_th;
    logic [3:0]    n_uh, n_um;
    logic [2:0]    n_tm;
    logic [5:0]    n_smin, n_ssec;
    logic [7:0]    sw_min_digits, sw_sec_digits;
    logic [3:0]    code;

    // Digit code -> active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Binary 0-59 -> {tens, units}; 60-63 shows dash on both digits
    function automatic logic [7:0] sw_split(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'd0;
        u = v[3:0];
        if (v >= 6'd60) begin
            t = CODE_DASH;
            u = CODE_DASH;
        end else if (v >= 6'd50) begin
            t = 4'd5; u = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            t = 4'd4; u = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            t = 4'd3; u = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            t = 4'd2; u = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            t = 4'd1; u = 4'(v - 6'd10);
        end
        return {t, u};
    endfunction

    // Scan/blink terminal counts and the snapshot that the next edge will hold
    always_comb begin
        ref_tc      = (ref_cnt == REF_LAST);
        blk_tc      = (blk_cnt == BLK_LAST);
        idx_nxt     = ref_tc ? idx + 2'd1 : idx;
        frame_start = ref_tc && (idx == 2'd3);
        phase_nxt   = blk_tc ? ~blink_phase : blink_phase;
        n_view      = frame_start ? view_sel         : sh_view;
        n_th        = frame_start ? tens_hours_in    : sh_th;
        n_uh        = frame_start ? units_hours_in   : sh_uh;
        n_tm        = frame_start ? tens_minutes_in  : sh_tm;
        n_um        = frame_start ? units_minutes_in : sh_um;
        n_smin      = frame_start ? stopwatch_min_in : sh_smin;
        n_ssec      = frame_start ? stopwatch_sec_in : sh_ssec;
        n_alarm     = frame_start ? alarm_sound      : sh_alarm;
    end

    // Pick the code for the digit that becomes active on the next edge
    always_comb begin
        sw_min_digits = sw_split(n_smin);
        sw_sec_digits = sw_split(n_ssec);
        code = CODE_BLANK;
        if (n_view) begin
            case (idx_nxt)
                2'd3:    code = sw_min_digits[7:4];
                2'd2:    code = sw_min_digits[3:0];
                2'd1:    code = sw_sec_digits[7:4];
                default: code = sw_sec_digits[3:0];
            endcase
        end else begin
            case (idx_nxt)
                2'd3:    code = (n_th == 2'd0) ? CODE_BLANK :
                                (n_th > 2'd2)  ? CODE_DASH  : {2'b00, n_th};
                2'd2:    code = (n_uh > 4'd9)  ? CODE_DASH  : n_uh;
                2'd1:    code = (n_tm > 3'd5)  ? CODE_DASH  : {1'b0, n_tm};
                default: code = (n_um > 4'd9)  ? CODE_DASH  : n_um;
            endcase
        end
    end

    // Counters, scan index, blink phase and frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt     <= REF_LAST;
            idx         <= 2'd3;
            blk_cnt     <= '0;
            blink_phase <= 1'b1;
            sh_view     <= 1'b0;
            sh_th       <= '0;
            sh_uh       <= '0;
            sh_tm       <= '0;
            sh_um       <= '0;
            sh_smin     <= '0;
            sh_ssec     <= '0;
            sh_alarm    <= 1'b0;
        end else begin
            ref_cnt     <= ref_tc ? '0 : ref_cnt + 1'b1;
            blk_cnt     <= blk_tc ? '0 : blk_cnt + 1'b1;
            idx         <= idx_nxt;
            blink_phase <= phase_nxt;
            sh_view     <= n_view;
            sh_th       <= n_th;
            sh_uh       <= n_uh;
            sh_tm       <= n_tm;
            sh_um       <= n_um;
            sh_smin     <= n_smin;
            sh_ssec     <= n_ssec;
            sh_alarm    <= n_alarm;
        end
    end

    // Registered outputs track the new index and snapshot on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 7'b1111111;
            an_out     <= 4'b1111;
            dp_out     <= 1'b1;
            buzzer_out <= 1'b0;
        end else begin
            seg_out    <= seg_of(code);
            an_out     <= (n_alarm && !phase_nxt) ? 4'b1111 : ~(4'b0001 << idx_nxt);
            dp_out     <= !((idx_nxt == 2'd2) && (n_view || phase_nxt));
            buzzer_out <= alarm_sound && phase_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Directed vector bench: two driver instances with different divider settings
// share inputs and are compared every cycle against a frame/blink model.
module tb_seven_seg_display_driver;

    localparam int RA = 4, BA = 8;
    localparam int RB = 3, BB = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       view_sel = 1'b0;
    logic [1:0] tens_hours_in = '0;
    logic [3:0] units_hours_in = '0;
    logic [2:0] tens_minutes_in = '0;
    logic [3:0] units_minutes_in = '0;
    logic [5:0] stopwatch_min_in = '0;
    logic [5:0] stopwatch_sec_in = '0;
    logic       alarm_sound = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b, bz_a, bz_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seven_seg_display_driver #(.REFRESH_DIV(RA), .BLINK_DIV(BA)) dut_a (
        .clk(clk), .rst(rst), .view_sel(view_sel),
        .tens_hours_in(tens_hours_in), .units_hours_in(units_hours_in),
        .tens_minutes_in(tens_minutes_in), .units_minutes_in(units_minutes_in),
        .stopwatch_min_in(stopwatch_min_in), .stopwatch_sec_in(stopwatch_sec_in),
        .alarm_sound(alarm_sound),
        .seg_out(seg_a), .an_out(an_a), .dp_out(dp_a), .buzzer_out(bz_a)
    );

    seven_seg_display_driver #(.REFRESH_DIV(RB), .BLINK_DIV(BB)) dut_b (
        .clk(clk), .rst(rst), .view_sel(view_sel),
        .tens_hours_in(tens_hours_in), .units_hours_in(units_hours_in),
        .tens_minutes_in(tens_minutes_in), .units_minutes_in(units_minutes_in),
        .stopwatch_min_in(stopwatch_min_in), .stopwatch_sec_in(stopwatch_sec_in),
        .alarm_sound(alarm_sound),
        .seg_out(seg_b), .an_out(an_b), .dp_out(dp_b), .buzzer_out(bz_b)
    );

    // segs packs the expected patterns as {digit3, digit2, digit1, digit0}
    typedef struct {
        logic        view;
        logic [1:0]  th;
        logic [3:0]  uh;
        logic [2:0]  tm;
        logic [3:0]  um;
        logic [5:0]  smin;
        logic [5:0]  ssec;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int k, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic apply(input int v, input logic alarm);
        view_sel         = vecs[v].view;
        tens_hours_in    = vecs[v].th;
        units_hours_in   = vecs[v].uh;
        tens_minutes_in  = vecs[v].tm;
        units_minutes_in = vecs[v].um;
        stopwatch_min_in = vecs[v].smin;
        stopwatch_sec_in = vecs[v].ssec;
        alarm_sound      = alarm;
    endtask

    // Expected outputs k edges after reset release for an instance with dividers r/b
    task automatic check_dut(input string tag, input int r, input int b, input int k,
                             input int vo, input int vn, input int chg, input logic alarm,
                             input logic [6:0] seg, input logic [3:0] an,
                             input logic dp, input logic bz);
        int d, f, ks, v;
        logic ph;
        logic [27:0] s;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic exp_dp;
        one = 4'b0001;
        d  = ((k - 1) / r) % 4;
        f  = (k - 1) / (4 * r);
        ks = 1 + 4 * r * f;
        v  = (ks > chg) ? vn : vo;
        ph = ((k / b) % 2) == 0;
        s  = vecs[v].segs;
        exp_an = (alarm && !ph) ? 4'b1111 : ~(one << d);
        exp_dp = !((d == 2) && (vecs[v].view || ph));
        chk({tag, "_seg"}, k, seg, s[7*d +: 7]);
        chk({tag, "_an"}, k, {3'b0, an}, {3'b0, exp_an});
        chk({tag, "_dp"}, k, {6'b0, dp}, {6'b0, exp_dp});
        chk({tag, "_buzzer"}, k, {6'b0, bz}, {6'b0, alarm && ph});
    endtask

    // Reset with inputs vo, release, run n edges; inputs switch to vn after edge chg
    task automatic run_seq(input int vo, input int vn, input int chg, input int n, input logic alarm);
        apply(vo, alarm);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_seg_a", 0, seg_a, 7'b1111111);
        chk("rst_an_a", 0, {3'b0, an_a}, 7'b0001111);
        chk("rst_dp_a", 0, {6'b0, dp_a}, 7'd1);
        chk("rst_buzzer_a", 0, {6'b0, bz_a}, 7'd0);
        chk("rst_an_b", 0, {3'b0, an_b}, 7'b0001111);
        chk("rst_seg_b", 0, seg_b, 7'b1111111);
        rst = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            check_dut("a", RA, BA, k, vo, vn, chg, alarm, seg_a, an_a, dp_a, bz_a);
            check_dut("b", RB, BB, k, vo, vn, chg, alarm, seg_b, an_b, dp_b, bz_b);
            if (k == chg) apply(vn, alarm);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd1, 4'd2, 3'd3, 4'd4, 6'd45, 6'd7,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{1'b1, 2'd1, 4'd2, 3'd3, 4'd4, 6'd45, 6'd7,
                    {7'b0011001, 7'b0010010, 7'b1000000, 7'b1111000}};
        vecs[2] = '{1'b0, 2'd0, 4'd9, 3'd5, 4'd9, 6'd0, 6'd0,
                    {7'b1111111, 7'b0010000, 7'b0010010, 7'b0010000}};
        vecs[3] = '{1'b0, 2'd3, 4'd12, 3'd6, 4'd15, 6'd0, 6'd0,
                    {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[4] = '{1'b1, 2'd2, 4'd3, 3'd4, 4'd5, 6'd63, 6'd60,
                    {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[5] = '{1'b1, 2'd0, 4'd0, 3'd0, 4'd0, 6'd59, 6'd0,
                    {7'b0010010, 7'b0010000, 7'b1000000, 7'b1000000}};
        vecs[6] = '{1'b0, 2'd2, 4'd8, 3'd0, 4'd6, 6'd12, 6'd34,
                    {7'b0100100, 7'b0000000, 7'b1000000, 7'b0000010}};

        for (int i = 0; i < 7; i++) run_seq(i, i, 1000, 24, 1'b0);

        // Alarm flashing: blank enables and silent buzzer in phase 0
        run_seq(0, 0, 1000, 24, 1'b1);

        // View switch while digit 1 is shown; old frame must finish intact
        run_seq(0, 1, 5, 20, 1'b0);

        // Stop mid-frame on digit 2, then reset over it and restart cleanly
        run_seq(2, 2, 1000, 10, 1'b0);
        run_seq(6, 6, 1000, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_display_driver.md
SEVEN_SEG_DISPLAY_DRIVER -- requirements
Module: seven_seg_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 1000: clk cycles each digit stays active; legal range >= 2.
REQ-002 Parameter BLINK_DIV, default 500000: clk cycles per blink half-period; legal range >= 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 view_sel  in  1  0 = clock view, 1 = stopwatch view.
REQ-006 tens_hours_in  in  2  clock tens-hours digit, legal 0-2.
REQ-007 units_hours_in  in  4  clock units-hours digit, legal 0-9.
REQ-008 tens_minutes_in  in  3  clock tens-minutes digit, legal 0-5.
REQ-009 units_minutes_in  in  4  clock units-minutes digit, legal 0-9.
REQ-010 stopwatch_min_in  in  6  stopwatch minutes, binary, legal 0-59.
REQ-011 stopwatch_sec_in  in  6  stopwatch seconds, binary, legal 0-59.
REQ-012 alarm_sound  in  1  alarm active level from the clock.
REQ-013 seg_out  out  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-014 an_out  out  4  digit enables, active-low, registered; bit 0 = rightmost digit.
REQ-015 dp_out  out  1  colon/decimal point, active-low, registered; lit only with digit 2.
REQ-016 buzzer_out  out  1  gated buzzer drive, active-high, registered.

Function
REQ-017 Refresh counter shall count 0..REFRESH_DIV-1 and wrap; at its terminal count, digit index shall advance 0->1->2->3->0.
REQ-018 Shadow registers shall capture view_sel and all data inputs on the edge where index goes 3->0; the displayed frame shall never mix two samples.
REQ-019 Outputs shall reflect the new index and the shadow values on the same edge that advances the index, with no added latency.
REQ-020 Clock view digits 3..0 shall show tens_hours, units_hours, tens_minutes, units_minutes.
REQ-021 Stopwatch view digits 3..0 shall show min/10, min%10, sec/10, sec%10, computed on the 6-bit binary values.
REQ-022 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
REQ-023 Clock-view digit over its legal range shall display dash; stopwatch value 60-63 shall display dash on both digits of that pair.
REQ-024 Clock view: tens_hours value 0 shall be blanked (seg blank, an bit still low).
REQ-025 Blink counter shall count 0..BLINK_DIV-1 and toggle blink_phase at terminal count, independent of the refresh counter.
REQ-026 dp_out on digit 2: stopwatch view constant lit; clock view lit only when blink_phase=1; other digits dp_out=1.
REQ-027 When shadowed alarm_sound=1 and blink_phase=0, an_out shall be 4'b1111; otherwise an_out = one-hot-low of index.
REQ-028 buzzer_out = alarm_sound (live input) AND blink_phase, registered one cycle.
REQ-029 view_sel change mid-frame shall take effect only at the next 3->0 index transition.

Reset
REQ-030 On rst=1: seg_out=7'b1111111, an_out=4'b1111, dp_out=1, buzzer_out=0, blink counter=0, blink_phase=1, shadows=0.
REQ-031 On rst=1: index=3, refresh counter=REFRESH_DIV-1, so the first cycle after release is a 3->0 transition that captures inputs and drives digit 0.
REQ-032 rst asserted mid-frame shall override all other activity on that edge; no partial frame survives.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-033 Reset, view 0, inputs 1/2/3/4 -> first edge after release an=1110, seg=0011001; each 4 cycles an steps 1101/1011/0111 with seg for 3,2,1.
REQ-034 View 1, min=45, sec=7 -> digits 3..0 show 4,5,0,7; dp_out=0 whenever an=1011.
REQ-035 Clock 0/9/5/9 -> digit 3 blank (seg 1111111, an 0111); units_hours=12 -> digit 2 dash 0111111.
REQ-036 alarm_sound=1 -> an_out=1111 and buzzer_out=0 during 8-cycle blink_phase=0 windows, normal scan and buzzer_out=1 in phase=1.
REQ-037 Toggle view_sel while index=1 -> digits keep old view until the next an=1110 edge, then all four switch.
REQ-038 Assert rst for one cycle while index=2 -> outputs return to REQ-030 values, scan restarts at digit 0 next cycle.
